fifo_burst_writer: RTL and testbench
====================================

FIFO_BURST_WRITER -- requirements
Module: fifo_burst_writer

Interface
REQ-001 SHALL have ports: WR_CLK  input  1  write-domain clock, all logic rising-edge.
REQ-002 SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have: start  input  1  burst request, sampled in IDLE only.
REQ-004 SHALL have: burst_len  input  4  words per burst; 0 means 16.
REQ-005 SHALL have: seed  input  4  first data word of burst.
REQ-006 SHALL have: abort  input  1  terminate burst early.
REQ-007 SHALL have: Full  input  1  FIFO full flag in WR_CLK domain; a word is accepted at an edge where push=1 and Full=0.
REQ-008 SHALL have: push  output  1  registered write request to FIFO.
REQ-009 SHALL have: Data_In  output  4  registered write data to FIFO.
REQ-010 SHALL have: busy  output  1  high in PUSH state.
REQ-011 SHALL have: done  output  1  one-cycle pulse at burst end.
REQ-012 SHALL have: aborted  output  1  set when burst ended by abort; cleared on next accepted start.
REQ-013 SHALL have: words_written  output  5  words accepted in current/last burst, 0..16.

Function
REQ-014 SHALL implement FSM states IDLE, PUSH, DONE; all outputs registered.
REQ-015 IDLE: start=1 at edge -> PUSH; latch remaining = (burst_len==0 ? 16 : burst_len); Data_In <= seed; push <= 1; words_written <= 0; aborted <= 0.
REQ-016 Latency: push high in cycle following the start edge; one word per cycle when Full=0.
REQ-017 PUSH, push=1, Full=1: stall; push, Data_In, remaining, words_written held unchanged.
REQ-018 PUSH, accept (push=1, Full=0): words_written +1; remaining -1; Data_In <= next pattern value.
REQ-019 Accept with remaining==1: push <= 0; state -> DONE.
REQ-020 DONE: done=1 for exactly one cycle, push=0; next state IDLE unconditionally.
REQ-021 start while in PUSH or DONE SHALL be ignored (not queued).
REQ-022 abort=1 in PUSH: push <= 0; aborted <= 1; state -> DONE; if the same edge is an accept, that word SHALL be counted in words_written.
REQ-023 abort in IDLE or DONE SHALL be ignored; abort and start both high in IDLE: start wins, abort ignored.
REQ-024 Default pattern: next = Data_In + 1, modulo 16 (15 -> 0 wrap).
REQ-025 Writer SHALL never present push=1 without a word pending (no push in IDLE/DONE).
REQ-026 words_written SHALL hold its final value in IDLE until next accepted start.

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE, push 0, Data_In 4'h0, busy 0, done 0, aborted 0, words_written 0, remaining 0.
REQ-028 rst mid-burst SHALL drop push asynchronously; no done pulse generated; burst not resumed after release.
REQ-029 First start is recognized at the first WR_CLK rising edge after rst deasserts.

Configuration
REQ-030 Macro FIFO_WR_LFSR_EN SHALL select data pattern.
REQ-031 Defined: next = {Data_In[2:0], Data_In[3]^Data_In[2]} (x^4+x^3+1, period 15); seed 0 SHALL be replaced by 4'h1 at start.
REQ-032 Undefined: incrementing pattern per REQ-024; seed used as-is including 0.

Verification
REQ-033 Burst: burst_len=4, seed=4'hE, Full=0 -> push high 4 cycles, Data_In E,F,0,1; done pulse next cycle; words_written=4.
REQ-034 Backpressure: burst_len=3, seed=2, Full=1 during cycles 2-4 of push -> word 3 held 3 cycles, sequence 2,3,4 each accepted once; words_written=3.
REQ-035 Length 0: burst_len=0, seed=0 -> 16 accepts, data 0..F, words_written=16, single done.
REQ-036 Abort: burst_len=8, abort on edge of 3rd accept -> push low next cycle, words_written=3, aborted=1, done pulse once.
REQ-037 Reset mid-burst: rst after 2 accepts of 6 -> push=0 immediately, words_written=0, no done; new start works.
REQ-038 FIFO_WR_LFSR_EN defined: seed=0, burst_len=4 -> Data_In 1,2,4,9.

Source files
------------

// File: rtl/fifo_burst_writer_if.sv
// fifo_burst_writer_if: burst request, FIFO write port and status bundle for fifo_burst_writer
interface fifo_burst_writer_if;
  logic start;
  logic [3:0] burst_len;
  logic [3:0] seed;
  logic abort;
  logic Full;
  logic push;
  logic [3:0] Data_In;
  logic busy;
  logic done;
  logic aborted;
  logic [4:0] words_written;
  modport master (
    output start, burst_len, seed, abort, Full,
    input push, Data_In, busy, done, aborted, words_written
  );
  modport slave (
    input start, burst_len, seed, abort, Full,
    output push, Data_In, busy, done, aborted, words_written
  );
endinterface

// File: rtl/fifo_burst_writer.sv
// fifo_burst_writer: pushes a seeded burst of words into a FIFO with stall/abort; FIFO_WR_LFSR_EN selects LFSR data
module fifo_burst_writer (
  input logic WR_CLK,
  input logic rst,
  fifo_burst_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PUSH, DONE} state_t;
  state_t state, state_nxt;
  logic [4:0] remaining, remaining_nxt, ww_nxt;
  logic [3:0] data_nxt, seed_eff, pattern;
  logic push_nxt, aborted_nxt, accept;
  assign accept = bus.push & ~bus.Full;
`ifdef FIFO_WR_LFSR_EN
  assign pattern = {bus.Data_In[2:0], bus.Data_In[3] ^ bus.Data_In[2]};
  assign seed_eff = (bus.seed == 4'h0) ? 4'h1 : bus.seed;
`else
  assign pattern = bus.Data_In + 4'd1;
  assign seed_eff = bus.seed;
`endif
  // state register
  always_ff @(posedge WR_CLK or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next state and next registered outputs; everything holds unless a transition says otherwise
  always_comb begin
    state_nxt = state;
    remaining_nxt = remaining;
    ww_nxt = bus.words_written;
    data_nxt = bus.Data_In;
    push_nxt = 1'b0;
    aborted_nxt = bus.aborted;
    case (state)
      IDLE: if (bus.start) begin
        state_nxt = PUSH;
        remaining_nxt = (bus.burst_len == 4'd0) ? 5'd16 : {1'b0, bus.burst_len};
        data_nxt = seed_eff;
        push_nxt = 1'b1;
        ww_nxt = 5'd0;
        aborted_nxt = 1'b0;
      end
      PUSH: begin
        push_nxt = bus.push;
        if (accept) begin
          ww_nxt = bus.words_written + 5'd1;
          remaining_nxt = remaining - 5'd1;
          data_nxt = pattern;
        end
        if (bus.abort) aborted_nxt = 1'b1;
        if (bus.abort || (accept && remaining == 5'd1)) begin
          push_nxt = 1'b0;
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // registered outputs; reset clears them immediately, dropping push mid-burst
  always_ff @(posedge WR_CLK or posedge rst)
    if (rst) begin
      bus.push <= 1'b0;
      bus.Data_In <= 4'h0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.aborted <= 1'b0;
      bus.words_written <= 5'd0;
      remaining <= 5'd0;
    end else begin
      bus.push <= push_nxt;
      bus.Data_In <= data_nxt;
      bus.busy <= (state_nxt == PUSH);
      bus.done <= (state_nxt == DONE);
      bus.aborted <= aborted_nxt;
      bus.words_written <= ww_nxt;
      remaining <= remaining_nxt;
    end
endmodule

// File: tb/tb_fifo_burst_writer.sv
// tb_fifo_burst_writer: scoreboard bench for fifo_burst_writer (bursts, stalls, length 0, abort, reset)
module tb_fifo_burst_writer;
  logic WR_CLK = 1'b0;
  logic rst = 1'b1;
  fifo_burst_writer_if bus();
  fifo_burst_writer dut (.WR_CLK(WR_CLK), .rst(rst), .bus(bus));
  always #5 WR_CLK = ~WR_CLK;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int push_cycles = 0;
  logic [3:0] exp_q[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [3:0] model_seed(input logic [3:0] s);
`ifdef FIFO_WR_LFSR_EN
    return (s == 4'h0) ? 4'h1 : s;
`else
    return s;
`endif
  endfunction
  function automatic logic [3:0] model_next(input logic [3:0] d);
`ifdef FIFO_WR_LFSR_EN
    return {d[2:0], d[3] ^ d[2]};
`else
    return d + 4'd1;
`endif
  endfunction
  // at negedge push/Full are stable for the coming edge: an accept there pops the scoreboard
  always @(negedge WR_CLK) if (!rst) begin
    if (bus.push) begin
      push_cycles++;
      check("push_busy", bus.busy, 1);
      if (!bus.Full) begin
        if (exp_q.size() == 0) check("extra_word", bus.Data_In, 32'hdead);
        else check("data", bus.Data_In, exp_q.pop_front());
      end
    end
    if (bus.done) begin
      done_cnt++;
      check("done_no_push", bus.push, 0);
    end
  end
  task automatic start_burst(input logic [3:0] len, input logic [3:0] s, input int n);
    logic [3:0] d;
    d = model_seed(s);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d);
      d = model_next(d);
    end
    done_cnt = 0;
    push_cycles = 0;
    bus.burst_len = len;
    bus.seed = s;
    bus.start = 1'b1;
    @(posedge WR_CLK); #1;
    bus.start = 1'b0;
    check("lat_push", bus.push, 1);
    check("lat_data", bus.Data_In, model_seed(s));
  endtask
  task automatic wait_done(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (bus.done) ok = 1'b1;
      else begin
        @(posedge WR_CLK); #1;
      end
    end
    check("done_timeout", ok, 1);
  endtask
  task automatic settle(input string tag);
    repeat (3) begin
      @(posedge WR_CLK); #1;
    end
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    check({tag, "_idle_push"}, bus.push, 0);
    check({tag, "_idle_busy"}, bus.busy, 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.burst_len = 4'd0;
    bus.seed = 4'd0;
    bus.abort = 1'b0;
    bus.Full = 1'b0;
    #12;
    check("rst_push", bus.push, 0);
    check("rst_data", bus.Data_In, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_aborted", bus.aborted, 0);
    check("rst_ww", bus.words_written, 0);
    @(posedge WR_CLK); #1;
    rst = 1'b0;
    start_burst(4'd4, 4'hE, 4);
    @(posedge WR_CLK); #1;
    bus.start = 1'b1;
    bus.seed = 4'h3;
    @(posedge WR_CLK); #1;
    bus.start = 1'b0;
    wait_done(40);
    check("b1_ww", bus.words_written, 4);
    check("b1_aborted", bus.aborted, 0);
    check("b1_push_cycles", push_cycles, 4);
    settle("b1");
    check("b1_ww_hold", bus.words_written, 4);
    start_burst(4'd3, 4'h2, 3);
    @(posedge WR_CLK); #1;
    bus.Full = 1'b1;
    repeat (3) begin
      @(posedge WR_CLK); #1;
      check("bp_hold_data", bus.Data_In, model_next(model_seed(4'h2)));
      check("bp_hold_ww", bus.words_written, 1);
      check("bp_hold_push", bus.push, 1);
    end
    bus.Full = 1'b0;
    wait_done(40);
    check("bp_ww", bus.words_written, 3);
    check("bp_push_cycles", push_cycles, 6);
    settle("bp");
    start_burst(4'd0, 4'h0, 16);
    wait_done(40);
    check("l0_ww", bus.words_written, 16);
    check("l0_push_cycles", push_cycles, 16);
    settle("l0");
    start_burst(4'd8, 4'h5, 3);
    repeat (2) begin
      @(posedge WR_CLK); #1;
    end
    bus.abort = 1'b1;
    @(posedge WR_CLK); #1;
    bus.abort = 1'b0;
    check("ab_push", bus.push, 0);
    check("ab_aborted", bus.aborted, 1);
    check("ab_ww", bus.words_written, 3);
    check("ab_done", bus.done, 1);
    bus.abort = 1'b1;
    settle("ab");
    check("ab_aborted_hold", bus.aborted, 1);
    start_burst(4'd2, 4'hA, 2);
    bus.abort = 1'b0;
    check("sa_aborted_clr", bus.aborted, 0);
    wait_done(40);
    check("sa_ww", bus.words_written, 2);
    check("sa_aborted", bus.aborted, 0);
    settle("sa");
    start_burst(4'd6, 4'h9, 6);
    @(posedge WR_CLK);
    @(posedge WR_CLK); #2;
    rst = 1'b1;
    #1;
    check("mr_push", bus.push, 0);
    check("mr_ww", bus.words_written, 0);
    check("mr_busy", bus.busy, 0);
    check("mr_data", bus.Data_In, 0);
    check("mr_popped", exp_q.size(), 4);
    exp_q.delete();
    done_cnt = 0;
    @(posedge WR_CLK); #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge WR_CLK); #1;
    end
    check("mr_no_done", done_cnt, 0);
    check("mr_no_resume", bus.push, 0);
    start_burst(4'd1, 4'h7, 1);
    wait_done(40);
    check("rc_ww", bus.words_written, 1);
    settle("rc");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
